dma_csr_regs: RTL and testbench
===============================

DMA_CSR_REGS -- requirements
Module: dma_csr_regs

Interface
REQ-001 SHALL have parameter CSR_ADDR_WIDTH, default 8, width of the CSR address.
REQ-002 SHALL have parameter CSR_DATA_WIDTH, default 32, width of CSR data; all register fields below fit within 32 bits.
REQ-003 SHALL have the port list below, one port per entry.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- csr_addr  in  CSR_ADDR_WIDTH  register address.
- csr_wen  in  1  one-cycle write strobe.
- csr_ren  in  1  one-cycle read strobe.
- csr_wdata  in  CSR_DATA_WIDTH  write data.
- csr_rdata  out  CSR_DATA_WIDTH  read data.
- dma_start  out  1  launch request, held until acknowledged.
- dma_ack  in  1  DMA accepted the launch.
- dma_beat  in  1  one data beat transferred.
- dma_done  in  1  DMA finished the transfer.
- dma_abort  out  1  one-cycle abort pulse.
- dma_layer  out  8  layer ID.
- dma_count  out  32  beat count.
- dma_burst  out  8  burst length.
- busy  out  1  transfer active.
- irq  out  1  level interrupt.

Function
REQ-004 SHALL decode the following registers; no other address has any effect.
- 0x50 LAYER: [7:0], RW.
- 0x51 CTRL: bit0 START (W1, reads 0); bit1 ABORT (W1, reads 0); bit2 IRQ_EN (RW).
- 0x52 COUNT: [31:0], RW.
- 0x53 STATUS: bit0 BUSY (RO); bit1 DONE (W1C); bit2 ERR (W1C); [15:8] DONE_CNT (RO); [31:16] REMAIN[15:0] (RO).
- 0x54 BURST: [7:0], RW; a write of 0 SHALL store 1.
REQ-005 SHALL drive csr_rdata combinationally from csr_addr regardless of csr_ren: zero-latency, 0 for unmapped addresses, reserved bits read 0; reads SHALL have no side effects.
REQ-006 SHALL ignore writes to LAYER, COUNT and BURST while BUSY=1; such a write SHALL set ERR.
REQ-007 SHALL implement the FSM IDLE -> REQ -> RUN -> IDLE, with the state visible via busy = (state != IDLE).
REQ-008 In IDLE, a START write with COUNT != 0 SHALL load the 32-bit REMAIN from COUNT and enter REQ on the next clock.
REQ-009 In IDLE, a START write with COUNT == 0 SHALL set ERR and stay in IDLE.
REQ-010 In REQ, dma_start SHALL be held at 1; dma_ack=1 SHALL move the FSM to RUN and dma_start SHALL deassert in the same cycle RUN is entered.
REQ-011 In RUN, each cycle with dma_beat=1 SHALL decrement REMAIN by 1, saturating at 0.
REQ-012 In RUN, dma_done=1 SHALL return the FSM to IDLE, set DONE and increment DONE_CNT (8-bit, wraps 255->0).
REQ-013 If dma_done and dma_beat are asserted in the same cycle, the beat SHALL be counted before the REMAIN check.
REQ-014 If REMAIN is not 0 after the final beat at dma_done, ERR SHALL also be set.
REQ-015 dma_done and dma_beat outside RUN SHALL be ignored.
REQ-016 An ABORT write in REQ or RUN SHALL pulse dma_abort for exactly 1 cycle, return the FSM to IDLE, set ERR, and leave DONE unchanged.
REQ-017 An ABORT write in IDLE SHALL have no effect.
REQ-018 If START and ABORT are written together, ABORT SHALL win: no launch occurs, and in IDLE the write is a no-op.
REQ-019 A START write while not in IDLE SHALL be ignored and SHALL set ERR.
REQ-020 When a W1C clear and a hardware set of DONE or ERR occur in the same cycle, the set SHALL win.
REQ-021 irq SHALL equal IRQ_EN & (DONE | ERR), registered.
REQ-022 dma_layer, dma_count and dma_burst SHALL be driven continuously from LAYER, COUNT and BURST.

Reset
REQ-023 While rst_n=0, all outputs SHALL be 0 except dma_burst=1, with FSM=IDLE and LAYER, COUNT, REMAIN, DONE_CNT, DONE, ERR and IRQ_EN all 0.
REQ-024 Asserting rst_n mid-transfer SHALL force IDLE immediately without pulsing dma_abort.

Verification
REQ-025 The bench SHALL cover the nominal transfer: write COUNT=4, BURST=2, CTRL=0x5; ack after 3 cycles; 4 beats; done -> dma_start high for exactly 3 cycles, STATUS reads 0x00000102, irq=1, and a W1C of 0x2 clears DONE and drops irq.
REQ-026 The bench SHALL cover a short transfer: COUNT=5, 3 beats, then done -> STATUS bits DONE=1 and ERR=1, REMAIN=2.
REQ-027 The bench SHALL cover abort: START, ack, 1 beat, then write CTRL=0x2 -> dma_abort high for 1 cycle, busy=0 the next cycle, ERR=1, DONE=0.
REQ-028 The bench SHALL cover illegal operations: START with COUNT=0 -> ERR=1 and dma_start never asserts; a write of BURST=0 reads back 1; a write of COUNT while busy leaves the old value and sets ERR.
REQ-029 The bench SHALL cover DONE_CNT wrap and set/clear collision: 256 transfers -> DONE_CNT=0; a W1C of DONE in the same cycle as dma_done leaves DONE=1.
REQ-030 The bench SHALL cover reset during RUN: rst_n low for 1 cycle -> all outputs at reset values, dma_abort stays 0, and an unmapped read at 0x60 returns 0.

Source files
------------

// File: rtl/dma_csr_regs.sv
// DMA control/status register block.
// Holds launch parameters, sequences one transfer and reports completion.
module dma_csr_regs #(
  parameter int CSR_ADDR_WIDTH = 8,
  parameter int CSR_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_addr,
  input  logic                      csr_wen,
  input  logic                      csr_ren,
  input  logic [CSR_DATA_WIDTH-1:0] csr_wdata,
  output logic [CSR_DATA_WIDTH-1:0] csr_rdata,
  output logic                      dma_start,
  input  logic                      dma_ack,
  input  logic                      dma_beat,
  input  logic                      dma_done,
  output logic                      dma_abort,
  output logic [7:0]                dma_layer,
  output logic [31:0]               dma_count,
  output logic [7:0]                dma_burst,
  output logic                      busy,
  output logic                      irq
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RUN
  } state_t;

  localparam logic [CSR_ADDR_WIDTH-1:0] A_LAYER  = CSR_ADDR_WIDTH'('h50);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_CTRL   = CSR_ADDR_WIDTH'('h51);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_COUNT  = CSR_ADDR_WIDTH'('h52);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_STATUS = CSR_ADDR_WIDTH'('h53);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_BURST  = CSR_ADDR_WIDTH'('h54);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  layer;
  logic [7:0]  burst;
  logic [7:0]  done_cnt;
  logic [31:0] count;
  logic [31:0] remain;
  logic [31:0] remain_beat;
  logic        irq_en;
  logic        done;
  logic        err;
  logic        abort_q;
  logic        irq_q;
  logic        unused;

  logic hit_layer, hit_ctrl, hit_count, hit_status, hit_burst;
  logic wr_layer, wr_ctrl, wr_count, wr_status, wr_burst;
  logic start_w, abort_w, in_busy;
  logic launch, finish, abort_go, set_err;

  assign unused = csr_ren;

  assign hit_layer  = csr_addr == A_LAYER;
  assign hit_ctrl   = csr_addr == A_CTRL;
  assign hit_count  = csr_addr == A_COUNT;
  assign hit_status = csr_addr == A_STATUS;
  assign hit_burst  = csr_addr == A_BURST;

  assign wr_layer  = csr_wen & hit_layer;
  assign wr_ctrl   = csr_wen & hit_ctrl;
  assign wr_count  = csr_wen & hit_count;
  assign wr_status = csr_wen & hit_status;
  assign wr_burst  = csr_wen & hit_burst;

  // abort dominates a simultaneous start
  assign abort_w = wr_ctrl & csr_wdata[1];
  assign start_w = wr_ctrl & csr_wdata[0] & ~csr_wdata[1];
  assign in_busy = state != IDLE;

  // a beat in the done cycle counts before the remain check
  assign remain_beat = (dma_beat && remain != '0) ? remain - 32'd1
                                                  : remain;

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    finish    = 1'b0;
    abort_go  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_w && count != '0) begin
          state_nxt = REQ;
          launch    = 1'b1;
        end
      end
      REQ: begin
        if (abort_w) begin
          state_nxt = IDLE;
          abort_go  = 1'b1;
        end else if (dma_ack) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort_w) begin
          state_nxt = IDLE;
          abort_go  = 1'b1;
        end else if (dma_done) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign set_err = abort_go
                 | (start_w & (in_busy | count == '0))
                 | (finish & remain_beat != '0)
                 | (in_busy & (wr_layer | wr_count | wr_burst));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      layer    <= '0;
      count    <= '0;
      burst    <= 8'd1;
      remain   <= '0;
      done_cnt <= '0;
      irq_en   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      abort_q  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      abort_q <= abort_go;
      irq_q   <= irq_en & (done | err);
      if (wr_layer && !in_busy) layer <= csr_wdata[7:0];
      if (wr_count && !in_busy) count <= csr_wdata[31:0];
      if (wr_burst && !in_busy)
        burst <= (csr_wdata[7:0] == 8'd0) ? 8'd1 : csr_wdata[7:0];
      if (wr_ctrl) irq_en <= csr_wdata[2];
      if (launch) remain <= count;
      else if (state == RUN && !abort_go) remain <= remain_beat;
      if (finish) done_cnt <= done_cnt + 8'd1;
      // hardware set wins over a same-cycle W1C
      done <= (done & ~(wr_status & csr_wdata[1])) | finish;
      err  <= (err & ~(wr_status & csr_wdata[2])) | set_err;
    end
  end

  always_comb begin
    csr_rdata = '0;
    unique case (1'b1)
      hit_layer:  csr_rdata[7:0] = layer;
      hit_ctrl:   csr_rdata[2] = irq_en;
      hit_count:  csr_rdata[31:0] = count;
      hit_status: begin
        csr_rdata[0]     = in_busy;
        csr_rdata[1]     = done;
        csr_rdata[2]     = err;
        csr_rdata[15:8]  = done_cnt;
        csr_rdata[31:16] = remain[15:0];
      end
      hit_burst:  csr_rdata[7:0] = burst;
      default:    ;
    endcase
  end

  assign dma_start = state == REQ;
  assign dma_abort = abort_q;
  assign busy      = in_busy;
  assign irq       = irq_q;
  assign dma_layer = layer;
  assign dma_count = count;
  assign dma_burst = burst;

endmodule

// File: tb/tb_dma_csr_regs.sv
// Directed bench for dma_csr_regs.
// Hand-computed expectations for transfer, abort, error and reset cases.
module tb_dma_csr_regs;

  localparam logic [7:0] A_LAYER  = 8'h50;
  localparam logic [7:0] A_CTRL   = 8'h51;
  localparam logic [7:0] A_COUNT  = 8'h52;
  localparam logic [7:0] A_STATUS = 8'h53;
  localparam logic [7:0] A_BURST  = 8'h54;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  csr_addr = '0;
  logic        csr_wen = 1'b0;
  logic        csr_ren = 1'b0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        dma_start;
  logic        dma_ack = 1'b0;
  logic        dma_beat = 1'b0;
  logic        dma_done = 1'b0;
  logic        dma_abort;
  logic [7:0]  dma_layer;
  logic [31:0] dma_count;
  logic [7:0]  dma_burst;
  logic        busy;
  logic        irq;

  int n_chk = 0;
  int n_pass = 0;

  dma_csr_regs dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .csr_addr  (csr_addr),
    .csr_wen   (csr_wen),
    .csr_ren   (csr_ren),
    .csr_wdata (csr_wdata),
    .csr_rdata (csr_rdata),
    .dma_start (dma_start),
    .dma_ack   (dma_ack),
    .dma_beat  (dma_beat),
    .dma_done  (dma_done),
    .dma_abort (dma_abort),
    .dma_layer (dma_layer),
    .dma_count (dma_count),
    .dma_burst (dma_burst),
    .busy      (busy),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic csr_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_addr  = a;
    csr_wdata = d;
    csr_wen   = 1'b1;
    @(negedge clk);
    csr_wen = 1'b0;
  endtask

  task automatic csr_rd(input logic [7:0] a, output logic [31:0] d);
    csr_addr = a;
    csr_ren  = 1'b1;
    #1;
    d = csr_rdata;
    csr_ren = 1'b0;
  endtask

  // start, ack, n beats, done; optional W1C of DONE in the done cycle
  task automatic xfer(input logic [31:0] ctrl, input int beats,
                      input bit collide);
    csr_wr(A_CTRL, ctrl);
    dma_ack = 1'b1;
    @(negedge clk);
    dma_ack = 1'b0;
    for (int i = 0; i < beats; i++) begin
      dma_beat = 1'b1;
      @(negedge clk);
    end
    dma_beat = 1'b0;
    dma_done = 1'b1;
    if (collide) begin
      csr_addr  = A_STATUS;
      csr_wdata = 32'h2;
      csr_wen   = 1'b1;
    end
    @(negedge clk);
    dma_done = 1'b0;
    csr_wen  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [31:0] rd;
  int st_cnt;
  bit seen;

  initial begin
    // reset state
    @(negedge clk);
    #1;
    chk("rst_burst", 32'(dma_burst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(dma_start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    csr_rd(A_STATUS, rd);
    chk("rst_status", rd, 32'h0);
    csr_rd(A_BURST, rd);
    chk("rst_burst_rd", rd, 32'h1);

    // nominal transfer
    csr_wr(A_LAYER, 32'hA5);
    csr_rd(A_LAYER, rd);
    chk("layer_rd", rd, 32'hA5);
    chk("layer_out", 32'(dma_layer), 32'hA5);
    csr_wr(A_COUNT, 32'd4);
    csr_wr(A_BURST, 32'd2);
    chk("count_out", dma_count, 32'd4);
    chk("burst_out", 32'(dma_burst), 32'd2);
    csr_wr(A_CTRL, 32'h5);
    st_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (dma_start) st_cnt++;
      if (i == 2) dma_ack = 1'b1;
      @(negedge clk);
    end
    dma_ack = 1'b0;
    chk("start_cycles", st_cnt, 3);
    chk("start_drop", 32'(dma_start), 32'd0);
    chk("run_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      dma_beat = 1'b1;
      @(negedge clk);
    end
    dma_beat = 1'b0;
    dma_done = 1'b1;
    @(negedge clk);
    dma_done = 1'b0;
    @(negedge clk);
    csr_rd(A_STATUS, rd);
    chk("nom_status", rd, 32'h0000_0102);
    chk("nom_irq", 32'(irq), 32'd1);
    csr_wr(A_STATUS, 32'h2);
    @(negedge clk);
    csr_rd(A_STATUS, rd);
    chk("w1c_status", rd, 32'h0000_0100);
    chk("w1c_irq", 32'(irq), 32'd0);

    // short transfer
    csr_wr(A_COUNT, 32'd5);
    xfer(32'h5, 3, 1'b0);
    csr_rd(A_STATUS, rd);
    chk("short_status", rd, 32'h0002_0206);

    // abort during RUN
    csr_wr(A_STATUS, 32'h6);
    csr_wr(A_CTRL, 32'h1);
    dma_ack = 1'b1;
    @(negedge clk);
    dma_ack  = 1'b0;
    dma_beat = 1'b1;
    @(negedge clk);
    dma_beat  = 1'b0;
    csr_addr  = A_CTRL;
    csr_wdata = 32'h2;
    csr_wen   = 1'b1;
    chk("pre_abort", 32'(dma_abort), 32'd0);
    @(negedge clk);
    csr_wen = 1'b0;
    chk("abort_pulse", 32'(dma_abort), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("abort_end", 32'(dma_abort), 32'd0);
    csr_rd(A_STATUS, rd);
    chk("abort_status", rd, 32'h0004_0204);

    // illegal operations
    csr_wr(A_STATUS, 32'h6);
    csr_wr(A_COUNT, 32'd0);
    csr_wr(A_CTRL, 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (dma_start) seen = 1'b1;
      @(negedge clk);
    end
    chk("zero_nostart", 32'(seen), 32'd0);
    csr_rd(A_STATUS, rd);
    chk("zero_status", rd, 32'h0004_0204);
    csr_wr(A_BURST, 32'd0);
    csr_rd(A_BURST, rd);
    chk("burst0_rd", rd, 32'h1);
    chk("burst0_out", 32'(dma_burst), 32'd1);
    csr_wr(A_STATUS, 32'h6);
    csr_wr(A_COUNT, 32'd7);
    csr_wr(A_CTRL, 32'h1);
    csr_wr(A_COUNT, 32'd9);
    csr_rd(A_COUNT, rd);
    chk("busy_count", rd, 32'd7);
    csr_rd(A_STATUS, rd);
    chk("busy_status", rd, 32'h0007_0205);
    csr_wr(A_CTRL, 32'h2);
    chk("clean_busy", 32'(busy), 32'd0);

    // DONE_CNT wrap and set/clear collision
    do_reset();
    csr_wr(A_COUNT, 32'd1);
    for (int i = 0; i < 255; i++) xfer(32'h1, 1, 1'b0);
    csr_rd(A_STATUS, rd);
    chk("cnt_255", rd, 32'h0000_FF02);
    csr_wr(A_STATUS, 32'h2);
    xfer(32'h1, 1, 1'b1);
    csr_rd(A_STATUS, rd);
    chk("cnt_wrap", rd, 32'h0000_0002);

    // reset during RUN
    csr_wr(A_LAYER, 32'h33);
    csr_wr(A_COUNT, 32'd3);
    csr_wr(A_CTRL, 32'h5);
    dma_ack = 1'b1;
    @(negedge clk);
    dma_ack  = 1'b0;
    dma_beat = 1'b1;
    @(negedge clk);
    dma_beat = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_start", 32'(dma_start), 32'd0);
    chk("mid_rst_abort", 32'(dma_abort), 32'd0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    chk("mid_rst_layer", 32'(dma_layer), 32'd0);
    chk("mid_rst_count", dma_count, 32'd0);
    chk("mid_rst_burst", 32'(dma_burst), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_abort", 32'(dma_abort), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    csr_rd(A_STATUS, rd);
    chk("post_rst_status", rd, 32'h0);
    csr_rd(8'h60, rd);
    chk("unmapped_60", rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
